seg_disp_arbiter: RTL and testbench
===================================

SEG_DISP_ARBITER -- requirements
Module: seg_disp_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_CYC, default 1024, giving the minimum owner display time in clk cycles (legal range 1 to 2^24-1).
REQ-002 The block SHALL have parameter BLANK_CYC, default 16, giving the blank-gap length in cycles (legal range 1 to 255, used only with SEG_ARB_BLANK_EN).
REQ-003 The block SHALL have port clk, input, 1 bit, the system clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port req, input, 3 bits, one display request per requester; bit i belongs to requester i.
REQ-006 The block SHALL have ports data0, data1 and data2, inputs, 64 bits each, the frame of requester i; [63:56] is digit 7 and [7:0] is digit 0, in segment-pattern format.
REQ-007 The block SHALL have port gnt, output, 3 bits, one-hot or zero, the current display owner.
REQ-008 The block SHALL have port disp_data, output, 64 bits, the registered frame driven to the segment scanner.
REQ-009 The block SHALL have port busy, output, 1 bit, high when the state is not IDLE.

Function
REQ-010 The state machine SHALL have states IDLE, HOLD and BLANK; BLANK exists only with SEG_ARB_BLANK_EN.
REQ-011 In IDLE with any req high, on the next edge the block SHALL grant the round-robin winner, enter HOLD, clear the hold counter, and load disp_data from the winner's data on that same edge.
REQ-012 Round-robin search SHALL start at (last_owner+1) mod 3; last_owner resets to 2, so requester 0 wins first after reset.
REQ-013 In HOLD, each edge with the owner's req high SHALL load disp_data from the owner's data (live update).
REQ-014 In HOLD, each edge with the owner's req low SHALL freeze disp_data and keep gnt unchanged until hold expiry.
REQ-015 The hold counter SHALL increment every HOLD cycle and saturate at HOLD_CYC-1; the hold is expired when the count equals HOLD_CYC-1.
REQ-016 At expiry with another req pending, the block SHALL hand over to the round-robin winner among the others: directly in one edge (same actions as REQ-011), or via BLANK with the macro defined.
REQ-017 At expiry with no other req pending and the owner's req high, the block SHALL stay in HOLD with the counter saturated; any later foreign req SHALL cause an immediate handover.
REQ-018 At expiry with no req high at all, the block SHALL go to IDLE, set gnt=0, and retain the last disp_data.
REQ-019 If all three req are high, the owners SHALL rotate 0->1->2->0, each owner holding exactly HOLD_CYC cycles (plus BLANK_CYC per switch if enabled).
REQ-020 A req arriving on the same edge as expiry SHALL be considered in that edge's arbitration.
REQ-021 gnt SHALL never have more than one bit set, and gnt SHALL be zero in IDLE and BLANK.
REQ-022 busy SHALL be a registered decode of the state.

Reset
REQ-023 While rst is low, the block SHALL set state=IDLE, gnt=0, disp_data=0, busy=0, hold counter=0, blank counter=0 and last_owner=2, independent of clk.
REQ-024 Reset asserted mid-HOLD or mid-BLANK SHALL abort the operation; after release, arbitration SHALL restart from requester 0 on the first edge.

Configuration
REQ-025 With macro SEG_ARB_BLANK_EN defined, a handover SHALL enter BLANK for exactly BLANK_CYC cycles with disp_data=0 and gnt=0, then re-arbitrate among the req high at BLANK exit; if none are high, the block SHALL go to IDLE.
REQ-026 With SEG_ARB_BLANK_EN undefined, no BLANK state or blank counter SHALL exist, and handover SHALL take one edge with no zero frame.

Verification
REQ-027 The bench SHALL check: reset, then req=001 and data0=0xFC00..00 -> the edge after req sees gnt=001, disp_data=data0 and busy=1.
REQ-028 The bench SHALL check, with HOLD_CYC=8: owner 0 held, req1 raised at cycle 2 -> gnt changes to 010 exactly 8 cycles after grant (+4 BLANK cycles of disp_data=0 with macro, BLANK_CYC=4).
REQ-029 The bench SHALL check: req=111 held for 40 cycles -> gnt sequence 001,010,100,001 with 8-cycle dwell each and never multi-hot.
REQ-030 The bench SHALL check: owner drops req at cycle 3 with no others pending -> disp_data frozen, gnt kept until cycle 8, then IDLE with gnt=0 and disp_data unchanged.
REQ-031 The bench SHALL check: rst pulsed low mid-HOLD of owner 2 -> all outputs 0 immediately; after release with req=110, the winner is requester 1.
REQ-032 The bench SHALL check: owner 1 changes data1 each cycle while req1 is high -> disp_data tracks it with one-cycle latency.

Source files
------------

// File: rtl/seg_disp_arbiter.sv
// rtl/seg_disp_arbiter.sv - round-robin owner arbiter for a shared 8-digit segment display
// Optional blank gap between owners: define SEG_ARB_BLANK_EN.
module seg_disp_arbiter #(
    parameter int HOLD_CYC  = 1024,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [63:0] data0,
    input  logic [63:0] data1,
    input  logic [63:0] data2,
    output logic [2:0]  gnt,
    output logic [63:0] disp_data,
    output logic        busy
);

`ifdef SEG_ARB_BLANK_EN
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_BLANK} state_t;
    localparam logic [7:0] BLANK_MAX = 8'(BLANK_CYC - 1);
    logic [7:0] blank_q, blank_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_HOLD} state_t;
`endif

    localparam logic [23:0] HOLD_MAX = 24'(HOLD_CYC - 1);

    state_t      state_q, state_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [63:0] disp_q, disp_d;
    logic [23:0] hold_q, hold_d;
    logic [1:0]  last_q, last_d;
    logic        busy_q;

    logic        do_grant;
    logic [2:0]  grant_mask;
    logic [1:0]  winner;
    logic [2:0]  others;
    logic        owner_req;
    logic        expired;

    // Search order starts just after the previous owner, which is therefore tried last.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] p0, p1, p2;
        case (last)
            2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
            2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
            default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
        endcase
        if (r[p0])      return p0;
        else if (r[p1]) return p1;
        else            return p2;
    endfunction

    function automatic logic [63:0] data_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return data0;
            2'd1:    return data1;
            default: return data2;
        endcase
    endfunction

    assign owner_req = req[last_q];
    assign others    = req & ~(3'b001 << last_q);
    assign expired   = (hold_q == HOLD_MAX);
    assign winner    = rr_pick(grant_mask, last_q);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        disp_d     = disp_q;
        hold_d     = hold_q;
        last_d     = last_q;
        do_grant   = 1'b0;
        grant_mask = req;
`ifdef SEG_ARB_BLANK_EN
        blank_d    = blank_q;
`endif
        case (state_q)
            S_IDLE: begin
                do_grant = |req;
            end
            S_HOLD: begin
                if (!expired) hold_d = hold_q + 24'd1;
                if (owner_req) disp_d = data_of(last_q);
                if (expired && (|others)) begin
`ifdef SEG_ARB_BLANK_EN
                    state_d = S_BLANK;
                    gnt_d   = 3'b000;
                    disp_d  = 64'd0;
                    blank_d = 8'd0;
`else
                    do_grant   = 1'b1;
                    grant_mask = others;
`endif
                end else if (expired && !owner_req) begin
                    state_d = S_IDLE;
                    gnt_d   = 3'b000;
                end
            end
`ifdef SEG_ARB_BLANK_EN
            S_BLANK: begin
                if (blank_q == BLANK_MAX) begin
                    if (|req) do_grant = 1'b1;
                    else      state_d  = S_IDLE;
                end else begin
                    blank_d = blank_q + 8'd1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                gnt_d   = 3'b000;
            end
        endcase

        if (do_grant) begin
            state_d = S_HOLD;
            gnt_d   = 3'b001 << winner;
            disp_d  = data_of(winner);
            hold_d  = 24'd0;
            last_d  = winner;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 3'b000;
            disp_q  <= 64'd0;
            hold_q  <= 24'd0;
            last_q  <= 2'd2;
            busy_q  <= 1'b0;
`ifdef SEG_ARB_BLANK_EN
            blank_q <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            disp_q  <= disp_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            busy_q  <= (state_d != S_IDLE);
`ifdef SEG_ARB_BLANK_EN
            blank_q <= blank_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign disp_data = disp_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// tb/tb_seg_disp_arbiter.sv - directed vector bench for seg_disp_arbiter (HOLD_CYC=8, default build)
module tb_seg_disp_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [63:0] data0 = 64'd0;
    logic [63:0] data1 = 64'd0;
    logic [63:0] data2 = 64'd0;
    logic [2:0]  gnt;
    logic [63:0] disp_data;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    seg_disp_arbiter #(.HOLD_CYC(8), .BLANK_CYC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .gnt       (gnt),
        .disp_data (disp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [2:0]  gnt;
        logic [63:0] disp;
        logic        busy;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(logic r, logic [2:0] q, logic [63:0] a, logic [63:0] b,
                                logic [2:0] g, logic [63:0] d, logic y);
        vec_t v;
        v.rst = r; v.req = q; v.d0 = a; v.d1 = b; v.gnt = g; v.disp = d; v.busy = y;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        req = 3'b000;
        step();
        rst = 1'b1;
    endtask

    localparam logic [63:0] FRAME0 = 64'hFC00_0000_0000_0000;
    localparam logic [63:0] A1 = 64'h1122_3344_5566_77A1;
    localparam logic [63:0] A2 = 64'h1122_3344_5566_77A2;
    localparam logic [63:0] B0 = 64'hB0B0_0000_1234_5678;

    initial begin
        // reset, first grant, live update, owner drop/freeze/idle, then owner 1 tracking
        tbl[0]  = mk(1'b0, 3'b000, 64'd0,  64'd0, 3'b000, 64'd0,  1'b0);
        tbl[1]  = mk(1'b1, 3'b001, FRAME0, 64'd0, 3'b001, FRAME0, 1'b1);
        tbl[2]  = mk(1'b1, 3'b001, A1,     64'd0, 3'b001, A1,     1'b1);
        tbl[3]  = mk(1'b1, 3'b001, A2,     64'd0, 3'b001, A2,     1'b1);
        tbl[4]  = mk(1'b1, 3'b000, 64'hA3, 64'd0, 3'b001, A2,     1'b1);
        tbl[5]  = mk(1'b1, 3'b000, 64'hA4, 64'd0, 3'b001, A2,     1'b1);
        tbl[6]  = mk(1'b1, 3'b000, 64'hA5, 64'd0, 3'b001, A2,     1'b1);
        tbl[7]  = mk(1'b1, 3'b000, 64'hA6, 64'd0, 3'b001, A2,     1'b1);
        tbl[8]  = mk(1'b1, 3'b000, 64'hA7, 64'd0, 3'b001, A2,     1'b1);
        tbl[9]  = mk(1'b1, 3'b000, 64'hA8, 64'd0, 3'b000, A2,     1'b0);
        tbl[10] = mk(1'b1, 3'b010, 64'hA8, B0,    3'b010, B0,     1'b1);
        tbl[11] = mk(1'b1, 3'b010, 64'hA8, 64'hB1, 3'b010, 64'hB1, 1'b1);
        tbl[12] = mk(1'b1, 3'b010, 64'hA8, 64'hB2, 3'b010, 64'hB2, 1'b1);
        tbl[13] = mk(1'b1, 3'b010, 64'hA8, 64'hB3, 3'b010, 64'hB3, 1'b1);

        for (int i = 0; i < 14; i++) begin
            rst   = tbl[i].rst;
            req   = tbl[i].req;
            data0 = tbl[i].d0;
            data1 = tbl[i].d1;
            step();
            chk($sformatf("vec%0d gnt", i),  {61'd0, gnt},  {61'd0, tbl[i].gnt});
            chk($sformatf("vec%0d disp", i), disp_data,     tbl[i].disp);
            chk($sformatf("vec%0d busy", i), {63'd0, busy}, {63'd0, tbl[i].busy});
        end

        // handover: owner 0 holds, req1 joins at cycle 2, gnt moves 8 cycles after grant
        do_reset();
        data0 = FRAME0;
        data1 = B0;
        req   = 3'b001;
        step();
        chk("ho grant", {61'd0, gnt}, 64'd1);
        for (int k = 1; k <= 8; k++) begin
            req = (k >= 2) ? 3'b011 : 3'b001;
            step();
            chk($sformatf("ho c%0d gnt", k), {61'd0, gnt}, (k == 8) ? 64'd2 : 64'd1);
        end
        chk("ho disp", disp_data, B0);

        // all requesting: 8-cycle rotation 0->1->2->0->1
        do_reset();
        data2 = 64'hC2;
        req   = 3'b111;
        for (int e = 1; e <= 40; e++) begin
            step();
            chk($sformatf("rot e%0d gnt", e), {61'd0, gnt}, 64'd1 << (((e - 1) / 8) % 3));
            chk($sformatf("rot e%0d onehot", e), {63'd0, $onehot0(gnt)}, 64'd1);
        end

        // sole owner stays saturated past expiry, then a late foreign req takes over at once
        do_reset();
        req = 3'b001;
        for (int k = 0; k < 12; k++) step();
        chk("sat gnt", {61'd0, gnt}, 64'd1);
        req = 3'b101;
        step();
        chk("sat handover gnt", {61'd0, gnt}, 64'd4);
        chk("sat handover disp", disp_data, 64'hC2);

        // reset mid-HOLD of owner 2, then restart from requester 0 search order
        do_reset();
        req = 3'b100;
        step();
        chk("r2 grant", {61'd0, gnt}, 64'd4);
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("async gnt",  {61'd0, gnt},  64'd0);
        chk("async disp", disp_data,     64'd0);
        chk("async busy", {63'd0, busy}, 64'd0);
        step();
        rst = 1'b1;
        req = 3'b110;
        step();
        chk("post-rst gnt",  {61'd0, gnt}, 64'd2);
        chk("post-rst disp", disp_data,    B0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
